// File: rtl/device_poll_scheduler_pkg.sv
//==============================================================================
// Package : device_poll_pkg -- RAM map, device indices and FSM encoding shared
//           by the device poll scheduler and its sub-blocks.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package device_poll_pkg;

  localparam int c_n_dev   = 4;
  localparam int c_dev_lmk = 0;
  localparam int c_dev_dac = 1;
  localparam int c_dev_adc = 2;
  localparam int c_dev_rf  = 3;
  localparam int c_src_i2c = 4;

  localparam logic [8:0] c_base_lmk  = 9'd1;
  localparam logic [8:0] c_base_dac  = 9'd50;
  localparam logic [8:0] c_base_adc  = 9'd53;
  localparam logic [8:0] c_base_rf   = 9'd64;
  localparam logic [8:0] c_base_temp = 9'd100;
  localparam logic [8:0] c_base_rtc  = 9'd101;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DEV_START = 3'd1,
    S_DEV_WAIT  = 3'd2,
    S_DEV_NEXT  = 3'd3,
    S_I2C_START = 3'd4,
    S_I2C_WAIT  = 3'd5,
    S_DONE      = 3'd6
  } poll_state_t;

  // Index 4 maps to the temperature slot so "next base" of RF is well defined.
  function automatic logic [8:0] dev_base(input logic [2:0] idx);
    case (idx)
      3'd0:    dev_base = c_base_lmk;
      3'd1:    dev_base = c_base_dac;
      3'd2:    dev_base = c_base_adc;
      3'd3:    dev_base = c_base_rf;
      default: dev_base = c_base_temp;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/device_poll_scheduler_if.sv
//==============================================================================
// Interface : device_poll_scheduler_if -- device/I2C readback handshakes, RAM
//             write port and round status of the poll scheduler.
// Rev       : 1.0
//==============================================================================
`default_nettype none

interface device_poll_scheduler_if;
  logic [3:0]   dev_rd_en;
  logic [3:0]   dev_rd_stat;
  logic [3:0]   dev_rd_valid;
  logic [127:0] dev_rd_data;
  logic         i2c_rd_stat;
  logic         i2c_rd_valid;
  logic [31:0]  i2c_rd_data;
  logic         i2c_rtc_valid;
  logic [31:0]  i2c_rtc_data;
  logic         ram_wen;
  logic [8:0]   ram_waddr;
  logic [31:0]  ram_wdata;
  logic         poll_done;
  logic         poll_overrun;
  logic [4:0]   timeout_flags;

  modport master (
    output dev_rd_en, dev_rd_stat, i2c_rd_stat, ram_wen, ram_waddr, ram_wdata,
           poll_done, poll_overrun, timeout_flags,
    input  dev_rd_valid, dev_rd_data, i2c_rd_valid, i2c_rd_data,
           i2c_rtc_valid, i2c_rtc_data
  );

  modport slave (
    input  dev_rd_en, dev_rd_stat, i2c_rd_stat, ram_wen, ram_waddr, ram_wdata,
           poll_done, poll_overrun, timeout_flags,
    output dev_rd_valid, dev_rd_data, i2c_rd_valid, i2c_rd_data,
           i2c_rtc_valid, i2c_rtc_data
  );
endinterface

`default_nettype wire

// File: rtl/device_poll_scheduler_poll_round_timer.sv
//==============================================================================
// Module : poll_round_timer -- free-running round period counter, held at zero
//          while the DSP is not ready; emits a one-cycle tick on wrap.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module poll_round_timer #(
  parameter logic [27:0] TIMING = 28'd20000000
) (
  input  wire logic spi_clk_in,
  input  wire logic spi_rst_in,
  input  wire logic i_rdy,
  output logic      o_tick
);

  logic [27:0] r_cnt;
  logic        w_wrap;

  assign w_wrap = (r_cnt == TIMING - 28'd1);
  assign o_tick = i_rdy && w_wrap;

  always_ff @(posedge spi_clk_in or posedge spi_rst_in) begin
    if (spi_rst_in) begin
      r_cnt <= '0;
    end else if (!i_rdy || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 28'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/device_poll_scheduler.sv
//==============================================================================
// Module : device_poll_scheduler -- periodic readback of LMK/DAC/ADC/RF (and
//          every I2C_DIV-th round the I2C sensors) into the device-info RAM.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module device_poll_scheduler
  import device_poll_pkg::*;
#(
  parameter logic [27:0] TIMING  = 28'd20000000,
  parameter int          LMK_CNT = 49,
  parameter int          DAC_CNT = 3,
  parameter int          ADC_CNT = 11,
  parameter int          RF_CNT  = 36,
  parameter int          I2C_DIV = 2,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  wire logic               spi_clk_in,
  input  wire logic               spi_rst_in,
  input  wire logic               dsp2fpga_dsp_rdy,
  device_poll_scheduler_if.master bus
);

  localparam int c_rnd_w = (I2C_DIV > 1) ? $clog2(I2C_DIV) : 1;

  logic               w_tick;
  poll_state_t        r_state, w_state_nxt;
  logic [1:0]         r_dev, w_dev_nxt;
  logic [8:0]         r_addr, w_addr_nxt;
  logic [7:0]         r_wcnt, w_wcnt_nxt;
  logic [15:0]        r_tcnt, w_tcnt_nxt;
  logic [c_rnd_w-1:0] r_round, w_round_nxt;
  logic               r_temp_got, w_temp_got_nxt;
  logic [1:0]         r_rtc_cnt, w_rtc_cnt_nxt;
  logic [3:0]         r_en, w_en_nxt, r_stat, w_stat_nxt;
  logic               r_i2c_stat, w_i2c_stat_nxt;
  logic               r_wen, w_wen_nxt;
  logic [8:0]         r_waddr, w_waddr_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic               r_done, w_done_nxt, r_ovr, w_ovr_nxt;
  logic [4:0]         r_flags, w_flags_nxt;
  logic [7:0]         w_dev_cnt;
  logic               w_sel_valid;
  logic [31:0]        w_sel_data;

  poll_round_timer #(.TIMING(TIMING)) u_timer (
    .spi_clk_in (spi_clk_in),
    .spi_rst_in (spi_rst_in),
    .i_rdy      (dsp2fpga_dsp_rdy),
    .o_tick     (w_tick)
  );

  always_comb begin
    case (r_dev)
      2'd0:    w_dev_cnt = 8'(LMK_CNT);
      2'd1:    w_dev_cnt = 8'(DAC_CNT);
      2'd2:    w_dev_cnt = 8'(ADC_CNT);
      default: w_dev_cnt = 8'(RF_CNT);
    endcase
  end

  // Only the lane of the device being served is ever looked at.
  assign w_sel_valid = bus.dev_rd_valid[r_dev];
  assign w_sel_data  = bus.dev_rd_data[{r_dev, 5'd0} +: 32];

  always_comb begin
    w_state_nxt    = r_state;
    w_dev_nxt      = r_dev;
    w_addr_nxt     = r_addr;
    w_wcnt_nxt     = r_wcnt;
    w_tcnt_nxt     = r_tcnt;
    w_round_nxt    = r_round;
    w_temp_got_nxt = r_temp_got;
    w_rtc_cnt_nxt  = r_rtc_cnt;
    w_en_nxt       = r_en;
    w_stat_nxt     = 4'd0;
    w_i2c_stat_nxt = 1'b0;
    w_wen_nxt      = 1'b0;
    w_waddr_nxt    = r_waddr;
    w_wdata_nxt    = r_wdata;
    w_done_nxt     = 1'b0;
    w_ovr_nxt      = w_tick && (r_state != S_IDLE);
    w_flags_nxt    = r_flags;

    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_flags_nxt = '0;
          w_dev_nxt   = 2'd0;
          w_addr_nxt  = c_base_lmk;
          w_state_nxt = S_DEV_START;
        end
      end
      S_DEV_START: begin
        w_stat_nxt  = 4'b0001 << r_dev;
        w_en_nxt    = 4'b0001 << r_dev;
        w_wcnt_nxt  = w_dev_cnt;
        w_tcnt_nxt  = '0;
        w_state_nxt = S_DEV_WAIT;
      end
      S_DEV_WAIT: begin
        if (r_wcnt == 8'd0) begin
          w_state_nxt = S_DEV_NEXT;
        end else if (w_sel_valid) begin
          w_wen_nxt   = 1'b1;
          w_waddr_nxt = r_addr;
          w_wdata_nxt = w_sel_data;
          w_addr_nxt  = r_addr + 9'd1;
          w_wcnt_nxt  = r_wcnt - 8'd1;
          // Restart at 1 so the timeout lands exactly TIMEOUT clocks after this pulse.
          w_tcnt_nxt  = 16'd1;
          if (r_wcnt == 8'd1) begin
            w_state_nxt = S_DEV_NEXT;
          end
        end else if (r_tcnt == TIMEOUT) begin
          w_flags_nxt[r_dev] = 1'b1;
          w_addr_nxt         = dev_base({1'b0, r_dev} + 3'd1);
          w_state_nxt        = S_DEV_NEXT;
        end else begin
          w_tcnt_nxt = r_tcnt + 16'd1;
        end
      end
      S_DEV_NEXT: begin
        w_en_nxt = 4'd0;
        if (r_dev != 2'd3) begin
          w_dev_nxt   = r_dev + 2'd1;
          w_state_nxt = S_DEV_START;
        end else if (r_round == '0) begin
          w_state_nxt = S_I2C_START;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_I2C_START: begin
        w_i2c_stat_nxt = 1'b1;
        w_tcnt_nxt     = '0;
        w_temp_got_nxt = 1'b0;
        w_rtc_cnt_nxt  = 2'd0;
        w_state_nxt    = S_I2C_WAIT;
      end
      S_I2C_WAIT: begin
        if (bus.i2c_rd_valid && !r_temp_got) begin
          w_wen_nxt      = 1'b1;
          w_waddr_nxt    = c_base_temp;
          w_wdata_nxt    = bus.i2c_rd_data;
          w_temp_got_nxt = 1'b1;
          w_tcnt_nxt     = 16'd1;
          if (r_rtc_cnt == 2'd2) begin
            w_state_nxt = S_DONE;
          end
        end else if (bus.i2c_rtc_valid && (r_rtc_cnt != 2'd2)) begin
          w_wen_nxt     = 1'b1;
          w_waddr_nxt   = c_base_rtc + {7'd0, r_rtc_cnt};
          w_wdata_nxt   = bus.i2c_rtc_data;
          w_rtc_cnt_nxt = r_rtc_cnt + 2'd1;
          w_tcnt_nxt    = 16'd1;
          if (r_temp_got && (r_rtc_cnt == 2'd1)) begin
            w_state_nxt = S_DONE;
          end
        end else if (r_tcnt == TIMEOUT) begin
          w_flags_nxt[c_src_i2c] = 1'b1;
          w_state_nxt            = S_DONE;
        end else begin
          w_tcnt_nxt = r_tcnt + 16'd1;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_round_nxt = (r_round == c_rnd_w'(I2C_DIV - 1)) ? '0 : r_round + 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge spi_clk_in or posedge spi_rst_in) begin
    if (spi_rst_in) begin
      r_state    <= S_IDLE;
      r_dev      <= '0;
      r_addr     <= '0;
      r_wcnt     <= '0;
      r_tcnt     <= '0;
      r_round    <= '0;
      r_temp_got <= 1'b0;
      r_rtc_cnt  <= '0;
      r_en       <= '0;
      r_stat     <= '0;
      r_i2c_stat <= 1'b0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
      r_flags    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dev      <= w_dev_nxt;
      r_addr     <= w_addr_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_round    <= w_round_nxt;
      r_temp_got <= w_temp_got_nxt;
      r_rtc_cnt  <= w_rtc_cnt_nxt;
      r_en       <= w_en_nxt;
      r_stat     <= w_stat_nxt;
      r_i2c_stat <= w_i2c_stat_nxt;
      r_wen      <= w_wen_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_done     <= w_done_nxt;
      r_ovr      <= w_ovr_nxt;
      r_flags    <= w_flags_nxt;
    end
  end

  assign bus.dev_rd_en     = r_en;
  assign bus.dev_rd_stat   = r_stat;
  assign bus.i2c_rd_stat   = r_i2c_stat;
  assign bus.ram_wen       = r_wen;
  assign bus.ram_waddr     = r_waddr;
  assign bus.ram_wdata     = r_wdata;
  assign bus.poll_done     = r_done;
  assign bus.poll_overrun  = r_ovr;
  assign bus.timeout_flags = r_flags;

endmodule

`default_nettype wire
